// File: rtl/otter_hazard_ctrl_if.sv
// ============================================================================
// Module   : otter_hazard_ctrl_if
// Brief    : Pipeline <-> hazard controller signal bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface otter_hazard_ctrl_if;
    logic [4:0] DEC_RS1;
    logic [4:0] DEC_RS2;
    logic       DEC_USES_RS1;
    logic       DEC_USES_RS2;
    logic [4:0] EX_RD;
    logic [4:0] MEM_RD;
    logic [4:0] WB_RD;
    logic       EX_REG_WRITE;
    logic       MEM_REG_WRITE;
    logic       WB_REG_WRITE;
    logic       EX_MEM_READ;
    logic       MEM_MEM_READ;
    logic       BR_TAKEN;
    logic [2:0] EX_PC_SRC;
    logic       INT_REQ;

    logic       PC_WRITE;
    logic [2:0] PC_SRC;
    logic       DECODE_EN;
    logic       CLEAR_DECODE;
    logic       CLEAR_EXECUTE;
    logic       INT_TAKEN;
    logic [1:0] FWD_A;
    logic [1:0] FWD_B;

    modport master (
        output DEC_RS1, DEC_RS2, DEC_USES_RS1, DEC_USES_RS2,
        output EX_RD, MEM_RD, WB_RD,
        output EX_REG_WRITE, MEM_REG_WRITE, WB_REG_WRITE,
        output EX_MEM_READ, MEM_MEM_READ,
        output BR_TAKEN, EX_PC_SRC, INT_REQ,
        input  PC_WRITE, PC_SRC, DECODE_EN, CLEAR_DECODE, CLEAR_EXECUTE,
        input  INT_TAKEN, FWD_A, FWD_B
    );

    modport slave (
        input  DEC_RS1, DEC_RS2, DEC_USES_RS1, DEC_USES_RS2,
        input  EX_RD, MEM_RD, WB_RD,
        input  EX_REG_WRITE, MEM_REG_WRITE, WB_REG_WRITE,
        input  EX_MEM_READ, MEM_MEM_READ,
        input  BR_TAKEN, EX_PC_SRC, INT_REQ,
        output PC_WRITE, PC_SRC, DECODE_EN, CLEAR_DECODE, CLEAR_EXECUTE,
        output INT_TAKEN, FWD_A, FWD_B
    );
endinterface

`default_nettype wire

// File: rtl/otter_hazard_ctrl.sv
// ============================================================================
// Module   : otter_hazard_ctrl
// Brief    : OTTER pipeline stall/flush/forward and interrupt-entry control.
//            Define OTTER_FWD_EN to enable operand forwarding.
// Revision : 1.0
// ============================================================================
`default_nettype none

module otter_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  wire logic          CLK,
    input  wire logic          RST_N,
    otter_hazard_ctrl_if.slave hz
);

    localparam logic [1:0] c_RUN   = 2'd0;
    localparam logic [1:0] c_FLUSH = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_ENTER = 2'd3;

    localparam logic [2:0] c_PC_SEQ   = 3'd0;
    localparam logic [2:0] c_PC_MTVEC = 3'd4;
    localparam logic [2:0] c_DRAIN_LD = 3'(DRAIN_CYCLES);

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q,   cnt_d;
    logic       w_load_use;
    logic       w_stall;

    function automatic logic f_match(input logic [4:0] rs, input logic used,
                                     input logic [4:0] rd, input logic en);
        return used && (rs != 5'd0) && (rs == rd) && en;
    endfunction

    always_comb begin
        w_load_use = f_match(hz.DEC_RS1, hz.DEC_USES_RS1, hz.EX_RD,  hz.EX_MEM_READ)
                   | f_match(hz.DEC_RS1, hz.DEC_USES_RS1, hz.MEM_RD, hz.MEM_MEM_READ)
                   | f_match(hz.DEC_RS2, hz.DEC_USES_RS2, hz.EX_RD,  hz.EX_MEM_READ)
                   | f_match(hz.DEC_RS2, hz.DEC_USES_RS2, hz.MEM_RD, hz.MEM_MEM_READ);
    end

`ifdef OTTER_FWD_EN
    logic [1:0] w_fwd_a, w_fwd_b;

    // Youngest producer wins; loads are never forwarded, they stall instead.
    function automatic logic [1:0] f_fwd(input logic [4:0] rs, input logic used,
                                         input logic [4:0] ex_rd, input logic ex_fwd,
                                         input logic [4:0] mem_rd, input logic mem_fwd,
                                         input logic [4:0] wb_rd, input logic wb_fwd);
        if (f_match(rs, used, ex_rd, ex_fwd))        return 2'b01;
        else if (f_match(rs, used, mem_rd, mem_fwd)) return 2'b10;
        else if (f_match(rs, used, wb_rd, wb_fwd))   return 2'b11;
        else                                         return 2'b00;
    endfunction

    always_comb begin
        w_fwd_a = f_fwd(hz.DEC_RS1, hz.DEC_USES_RS1,
                        hz.EX_RD,  hz.EX_REG_WRITE  && !hz.EX_MEM_READ,
                        hz.MEM_RD, hz.MEM_REG_WRITE && !hz.MEM_MEM_READ,
                        hz.WB_RD,  hz.WB_REG_WRITE);
        w_fwd_b = f_fwd(hz.DEC_RS2, hz.DEC_USES_RS2,
                        hz.EX_RD,  hz.EX_REG_WRITE  && !hz.EX_MEM_READ,
                        hz.MEM_RD, hz.MEM_REG_WRITE && !hz.MEM_MEM_READ,
                        hz.WB_RD,  hz.WB_REG_WRITE);
        w_stall = w_load_use;
    end
`else
    logic [1:0] w_fwd_a, w_fwd_b;
    logic       w_raw;

    // Without bypass paths any in-flight producer must reach the register file first.
    always_comb begin
        w_raw = f_match(hz.DEC_RS1, hz.DEC_USES_RS1, hz.EX_RD,  hz.EX_REG_WRITE)
              | f_match(hz.DEC_RS1, hz.DEC_USES_RS1, hz.MEM_RD, hz.MEM_REG_WRITE)
              | f_match(hz.DEC_RS1, hz.DEC_USES_RS1, hz.WB_RD,  hz.WB_REG_WRITE)
              | f_match(hz.DEC_RS2, hz.DEC_USES_RS2, hz.EX_RD,  hz.EX_REG_WRITE)
              | f_match(hz.DEC_RS2, hz.DEC_USES_RS2, hz.MEM_RD, hz.MEM_REG_WRITE)
              | f_match(hz.DEC_RS2, hz.DEC_USES_RS2, hz.WB_RD,  hz.WB_REG_WRITE);
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        w_stall = w_load_use | w_raw;
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= c_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_RUN: begin
                if (hz.BR_TAKEN) begin
                    state_d = c_FLUSH;
                end else if (hz.INT_REQ) begin
                    state_d = c_DRAIN;
                    cnt_d   = c_DRAIN_LD;
                end
            end
            c_DRAIN: begin
                // Entry is committed once accepted; INT_REQ is not re-examined.
                if (cnt_q <= 3'd1) begin
                    state_d = c_ENTER;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                end
            end
            c_ENTER: state_d = c_FLUSH;
            c_FLUSH: state_d = c_RUN;
            default: state_d = c_RUN;
        endcase
    end

    always_comb begin
        hz.PC_WRITE      = 1'b1;
        hz.PC_SRC        = c_PC_SEQ;
        hz.DECODE_EN     = 1'b1;
        hz.CLEAR_DECODE  = 1'b0;
        hz.CLEAR_EXECUTE = 1'b0;
        hz.INT_TAKEN     = 1'b0;
        hz.FWD_A         = w_fwd_a;
        hz.FWD_B         = w_fwd_b;
        if (!RST_N) begin
            hz.PC_WRITE      = 1'b0;
            hz.DECODE_EN     = 1'b0;
            hz.CLEAR_DECODE  = 1'b1;
            hz.CLEAR_EXECUTE = 1'b1;
            hz.FWD_A         = 2'b00;
            hz.FWD_B         = 2'b00;
        end else begin
            case (state_q)
                c_RUN: begin
                    if (hz.BR_TAKEN) begin
                        hz.PC_SRC        = hz.EX_PC_SRC;
                        hz.CLEAR_DECODE  = 1'b1;
                        hz.CLEAR_EXECUTE = 1'b1;
                    end else if (w_stall) begin
                        hz.PC_WRITE      = 1'b0;
                        hz.DECODE_EN     = 1'b0;
                        hz.CLEAR_EXECUTE = 1'b1;
                    end
                end
                c_FLUSH: begin
                    // Kill the instruction fetched from the stale PC by the synchronous memory.
                    hz.CLEAR_DECODE = 1'b1;
                end
                c_DRAIN: begin
                    hz.PC_WRITE      = 1'b0;
                    hz.DECODE_EN     = 1'b0;
                    hz.CLEAR_EXECUTE = 1'b1;
                end
                c_ENTER: begin
                    hz.INT_TAKEN     = 1'b1;
                    hz.PC_SRC        = c_PC_MTVEC;
                    hz.CLEAR_DECODE  = 1'b1;
                    hz.CLEAR_EXECUTE = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/otter_hazard_ctrl.md
OTTER_HAZARD_CTRL -- requirements
Module: otter_hazard_ctrl

Interface
REQ-001 SHALL provide parameter DRAIN_CYCLES, default 3, the number of cycles older instructions need to retire before interrupt entry (legal range 1..7).
REQ-002 SHALL have port CLK  input  1  single rising-edge clock.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports DEC_RS1, DEC_RS2  input  5 each  source registers of the instruction in decode.
REQ-005 SHALL have ports DEC_USES_RS1, DEC_USES_RS2  input  1 each  decode instruction reads that source.
REQ-006 SHALL have ports EX_RD, MEM_RD, WB_RD  input  5 each  destination register per stage.
REQ-007 SHALL have ports EX_REG_WRITE, MEM_REG_WRITE, WB_REG_WRITE  input  1 each  stage writes the register file.
REQ-008 SHALL have ports EX_MEM_READ, MEM_MEM_READ  input  1 each  stage holds a load.
REQ-009 SHALL have ports BR_TAKEN  input  1  and EX_PC_SRC  input  3  taken branch/jump in execute, with its PC mux select.
REQ-010 SHALL have port INT_REQ  input  1  interrupt request, already masked by MIE.
REQ-011 SHALL have outputs PC_WRITE 1, PC_SRC 3, DECODE_EN 1, CLEAR_DECODE 1, CLEAR_EXECUTE 1, INT_TAKEN 1, FWD_A 2, FWD_B 2.

Function
REQ-012 SHALL implement states RUN, FLUSH, DRAIN and ENTER, with registered state and combinational outputs.
REQ-013 SHALL, in RUN with no event, drive PC_WRITE=1, PC_SRC=0, DECODE_EN=1, all clears=0 and INT_TAKEN=0.
REQ-014 SHALL detect a load-use hazard when a used DEC_RSx is nonzero and equals EX_RD with EX_MEM_READ=1, or equals MEM_RD with MEM_MEM_READ=1.
REQ-015 SHALL, on a load-use hazard in RUN, drive PC_WRITE=0, DECODE_EN=0 and CLEAR_EXECUTE=1, repeating every cycle the hazard holds (2 cycles when the load is in EX).
REQ-016 SHALL give BR_TAKEN priority over a load-use hazard and INT_REQ: PC_WRITE=1, PC_SRC=EX_PC_SRC, CLEAR_DECODE=1, CLEAR_EXECUTE=1, then go to FLUSH.
REQ-017 SHALL, in FLUSH, drive CLEAR_DECODE=1, PC_WRITE=1, PC_SRC=0, to discard the synchronous-read instruction from the old PC, then return to RUN; BR_TAKEN in FLUSH is ignored.
REQ-018 SHALL accept INT_REQ only in RUN with BR_TAKEN=0, load counter to DRAIN_CYCLES and go to DRAIN.
REQ-019 SHALL, in DRAIN, drive PC_WRITE=0, DECODE_EN=0 and CLEAR_EXECUTE=1, decrementing the counter each cycle and entering ENTER when it reaches 0.
REQ-020 SHALL commit an accepted interrupt: INT_REQ deasserting during DRAIN SHALL NOT abort entry.
REQ-021 SHALL, in ENTER (exactly 1 cycle), drive INT_TAKEN=1, PC_WRITE=1, PC_SRC=3'd4 (mtvec), CLEAR_DECODE=1 and CLEAR_EXECUTE=1, then go to FLUSH.
REQ-022 SHALL compute FWD_x combinationally per used source: 01 if it matches EX_RD with EX_REG_WRITE and no load; else 10 if it matches MEM_RD with MEM_REG_WRITE and no load; else 11 if it matches WB_RD with WB_REG_WRITE; else 00.
REQ-023 SHALL never forward or stall on register x0.

Reset
REQ-024 SHALL, while RST_N=0, force state RUN and counter 0, and drive PC_WRITE=0, DECODE_EN=0, CLEAR_DECODE=1, CLEAR_EXECUTE=1, PC_SRC=0, INT_TAKEN=0 and FWD_A=FWD_B=00.
REQ-025 SHALL abandon any DRAIN, ENTER or FLUSH in progress when reset asserts mid-operation, with no INT_TAKEN pulse after release.
REQ-026 SHALL enter RUN behaviour on the first CLK edge after RST_N rises.

Configuration
REQ-027 SHALL, with OTTER_FWD_EN defined, implement forwarding per REQ-022.
REQ-028 SHALL, without OTTER_FWD_EN, tie FWD_A and FWD_B to 00 and treat any used-source match against a writing EX, MEM or WB destination as a stall per REQ-015.

Verification
REQ-029 SHALL verify load-use: EX holds lw x5 and decode holds add x6,x5,x1 -> PC_WRITE=0 for 2 cycles, then FWD_A=11 on the third cycle.
REQ-030 SHALL verify forwarding: EX holds addi x7 and decode reads x7 on rs2 -> FWD_B=01 with no stall; with rs2=x0 -> FWD_B=00.
REQ-031 SHALL verify branch: BR_TAKEN=1 with EX_PC_SRC=2 -> same cycle PC_SRC=2 and both clears=1; next cycle only CLEAR_DECODE=1; then RUN.
REQ-032 SHALL verify interrupt: INT_REQ pulsed 1 cycle in RUN -> 3 DRAIN cycles with PC_WRITE=0, then one INT_TAKEN=1 cycle with PC_SRC=4, then FLUSH.
REQ-033 SHALL verify priority: BR_TAKEN, INT_REQ and a load-use hazard asserted together -> branch redirect with no DRAIN entry.
REQ-034 SHALL verify reset mid-drain: RST_N low on the 2nd DRAIN cycle -> reset values immediately, and no INT_TAKEN pulse after release.
